// File: rtl/led_pattern_bank_if.sv
// Channel configuration port. Switch/control logic is the master and the LED bank is the slave.
interface led_pattern_bank_if #(
  parameter int CH_W     = 2,
  parameter int PERIOD_W = 12,
  parameter int PWM_W    = 4
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_chan;
  logic [1:0]          cfg_mode;
  logic [PERIOD_W-1:0] cfg_period;
  logic [PWM_W-1:0]    cfg_duty;

  modport master (output cfg_valid, cfg_chan, cfg_mode, cfg_period, cfg_duty,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_chan, cfg_mode, cfg_period, cfg_duty,
                  output cfg_ready);
endinterface

// File: rtl/led_pattern_bank.sv
// Multi-channel LED driver: OFF/ON/BLINK/DIM per channel, a shared tick prescaler and a shared PWM
// counter. Each channel is configured through a valid/ready port.
module led_pattern_chan #(
  parameter int PERIOD_W       = 12,
  parameter int PWM_W          = 4,
  parameter int DEFAULT_PERIOD = 208
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ld_i,
  input  logic [1:0]          mode_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [PWM_W-1:0]    duty_i,
  input  logic                tick_i,
  input  logic [PWM_W-1:0]    pwm_i,
  output logic                led_o
);
  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_DIM   = 2'b11;

  logic [1:0]          mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PWM_W-1:0]    duty_q, duty_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic                led_q, led_d;
  logic [PERIOD_W-1:0] last;

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    // A zero half-period behaves as one tick, so the count never runs past last.
    last     = (period_q == '0) ? '0 : period_q - 1'b1;
    if (ld_i) begin
      // A load in the same cycle as a tick takes priority; that tick is dropped.
      mode_d   = mode_i;
      period_d = period_i;
      duty_d   = duty_i;
      cnt_d    = '0;
      phase_d  = 1'b1;
    end else if (tick_i && mode_q == MODE_BLINK) begin
      if (cnt_q == last) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    case (mode_q)
      MODE_OFF:   led_d = 1'b0;
      MODE_ON:    led_d = 1'b1;
      MODE_BLINK: led_d = phase_q;
      MODE_DIM:   led_d = (pwm_i < duty_q);
      default:    led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q   <= MODE_OFF;
      period_q <= PERIOD_W'(DEFAULT_PERIOD);
      duty_q   <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;
endmodule

module led_pattern_bank #(
  parameter int NUM_LEDS       = 4,
  parameter int CLK_HZ         = 24_000_000,
  parameter int TICK_HZ        = 1_000,
  parameter int PERIOD_W       = 12,
  parameter int PWM_W          = 4,
  parameter int DEFAULT_PERIOD = 208,
  localparam int CH_W          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                int_osc,
  input  logic                reset,
  led_pattern_bank_if.slave   cfg,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(TICK_DIV);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PWM_W-1:0]    pwm_q;
  logic                ready_q;
  logic                accept;
  logic [NUM_LEDS-1:0] ld;

  assign tick    = (presc_q == PRE_W'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  assign accept        = cfg.cfg_valid & ready_q;
  assign cfg.cfg_ready = ready_q;

  always_ff @(posedge int_osc) begin
    if (!reset) begin
      presc_q <= '0;
      pwm_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_q + 1'b1;
      // One idle cycle after every accept, otherwise always ready.
      ready_q <= ~accept;
    end
  end

  // Out-of-range channels complete the handshake but select no lane.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
    assign ld[i] = accept && (cfg.cfg_chan == CH_W'(i));

    led_pattern_chan #(
      .PERIOD_W       (PERIOD_W),
      .PWM_W          (PWM_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .clk_i    (int_osc),
      .rst_ni   (reset),
      .ld_i     (ld[i]),
      .mode_i   (cfg.cfg_mode),
      .period_i (cfg.cfg_period),
      .duty_i   (cfg.cfg_duty),
      .tick_i   (tick),
      .pwm_i    (pwm_q),
      .led_o    (led[i])
    );
  end
endmodule

// File: tb/tb_led_pattern_bank.sv
// Directed bench for led_pattern_bank: stimulus pushes cycle-stamped expectations into a scoreboard,
// and a negedge monitor compares them against the LED, ready and tick outputs.
module tb_led_pattern_bank;
  localparam int K_LED = 0, K_RDY = 1, K_TICK = 2;
  localparam logic [1:0] M_OFF = 2'b00, M_ON = 2'b01, M_BLINK = 2'b10, M_DIM = 2'b11;

  typedef struct {
    int         cyc;
    int         kind;
    logic [2:0] mask;
    logic [2:0] exp;
    string      name;
  } exp_t;

  logic       int_osc = 1'b0;
  logic       reset;
  logic [2:0] led;
  logic       tick;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  logic [2:0] act;

  led_pattern_bank_if #(.CH_W(2), .PERIOD_W(12), .PWM_W(4)) cif ();

  led_pattern_bank #(
    .NUM_LEDS(3), .CLK_HZ(100), .TICK_HZ(10), .PERIOD_W(12), .PWM_W(4), .DEFAULT_PERIOD(208)
  ) dut (
    .int_osc (int_osc),
    .reset   (reset),
    .cfg     (cif),
    .led     (led),
    .tick    (tick)
  );

  always #5 int_osc = ~int_osc;
  always @(posedge int_osc) cyc <= cyc + 1;

  function automatic void expect_at(int c, int k, logic [2:0] m, logic [2:0] e, string n);
    exp_t x;
    x.cyc = c; x.kind = k; x.mask = m; x.exp = e; x.name = n;
    sb.push_back(x);
  endfunction

  // Monitor: compare every expectation stamped with the edge count just completed.
  always @(negedge int_osc) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].kind)
          K_LED:   act = led;
          K_RDY:   act = {2'b00, cif.cfg_ready};
          default: act = {2'b00, tick};
        endcase
        n_tests++;
        if (sb[i].cyc < cyc || (act & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
          n_fail++;
          $display("FAIL %s @cyc %0d (due %0d): got %b expected %b", sb[i].name, cyc, sb[i].cyc,
                   act & sb[i].mask, sb[i].exp & sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  // Called #1 after an edge; returns once edge count reaches c.
  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge int_osc);
      #1;
    end
  endtask

  // Holds valid until an edge where ready was high; acc is that edge's number.
  task automatic cfg(input int ch, input logic [1:0] m, input int p, input int d, output int acc);
    logic r;
    cif.cfg_valid  = 1'b1;
    cif.cfg_chan   = 2'(ch);
    cif.cfg_mode   = m;
    cif.cfg_period = 12'(p);
    cif.cfg_duty   = 4'(d);
    acc = -1;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      r = cif.cfg_ready;
      @(posedge int_osc);
      #1;
      if (r) acc = cyc;
    end
    cif.cfg_valid = 1'b0;
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL cfg_timeout ch%0d: got no accept expected accept within 20 clks", ch);
      acc = cyc;
    end
  endtask

  // Tick edges (before the second reset) are 15, 25, 35, ...
  function automatic int next_tick(int after);
    int e = 15;
    while (e <= after) e += 10;
    return e;
  endfunction

  // ch1 BLINK period 3 accepted at edge a: toggles every third tick edge after a.
  function automatic logic ch1_exp(int a, int m);
    int n = 0;
    for (int e = 15; e <= m - 1; e += 10) if (e > a) n++;
    return ((n / 3) % 2) == 0;
  endfunction

  initial begin
    int a, b, c, n, te, e, f, g;
    reset = 1'b0;
    cif.cfg_valid = 1'b0; cif.cfg_chan = '0; cif.cfg_mode = '0;
    cif.cfg_period = '0; cif.cfg_duty = '0;

    // 1: reset held five clocks, then release
    expect_at(3, K_LED, 3'b111, 3'b000, "rst_led");
    expect_at(5, K_LED, 3'b111, 3'b000, "rst_led_end");
    expect_at(5, K_RDY, 3'b001, 3'b000, "rst_ready");
    expect_at(5, K_TICK, 3'b001, 3'b000, "rst_tick");
    step_to(5);
    reset = 1'b1;
    expect_at(6, K_RDY, 3'b001, 3'b001, "rel_ready");
    expect_at(6, K_LED, 3'b111, 3'b000, "rel_led");
    expect_at(13, K_TICK, 3'b001, 3'b000, "tick_pre");
    expect_at(14, K_TICK, 3'b001, 3'b001, "tick_hi");
    expect_at(15, K_TICK, 3'b001, 3'b000, "tick_lo");

    // 2: ch1 BLINK period 3
    step_to(16);
    cfg(1, M_BLINK, 3, 0, a);
    expect_at(a, K_RDY, 3'b001, 3'b000, "acc_ready_lo");
    expect_at(a + 1, K_RDY, 3'b001, 3'b001, "acc_ready_hi");
    expect_at(a + 1, K_LED, 3'b111, 3'b010, "blink_first");
    for (int m = a + 1; m <= a + 100; m++)
      expect_at(m, K_LED, 3'b010, {1'b0, ch1_exp(a, m), 1'b0}, "ch1_blink");

    // 3: ch0 DIM duty 4, then duty 0; pwm value after edge m is (m-5)%16
    step_to(a + 2);
    cfg(0, M_DIM, 0, 4, b);
    for (int m = b + 2; m <= b + 17; m++)
      expect_at(m, K_LED, 3'b001, {2'b00, ((m - 6) % 16) < 4}, "dim4");
    step_to(b + 18);
    cfg(0, M_DIM, 0, 0, c);
    for (int m = c + 1; m <= c + 16; m++)
      expect_at(m, K_LED, 3'b001, 3'b000, "dim0");

    // 4: valid held three clocks: ON accepted, OFF skipped, DIM duty 0 accepted
    step_to(next_tick(c + 17) + 2);
    n = cyc;
    expect_at(n + 1, K_RDY, 3'b001, 3'b000, "hold_rdy1");
    expect_at(n + 2, K_RDY, 3'b001, 3'b001, "hold_rdy2");
    expect_at(n + 3, K_RDY, 3'b001, 3'b000, "hold_rdy3");
    expect_at(n + 4, K_RDY, 3'b001, 3'b001, "hold_rdy4");
    expect_at(n + 2, K_LED, 3'b100, 3'b100, "hold_led_on");
    expect_at(n + 3, K_LED, 3'b100, 3'b100, "hold_led_skip");
    expect_at(n + 4, K_LED, 3'b100, 3'b000, "hold_led_last");
    expect_at(n + 5, K_LED, 3'b100, 3'b000, "hold_led_last2");
    cif.cfg_valid = 1'b1; cif.cfg_chan = 2'd2; cif.cfg_mode = M_ON; cif.cfg_duty = 4'd0;
    step_to(n + 1);
    cif.cfg_mode = M_OFF;
    step_to(n + 2);
    cif.cfg_mode = M_DIM;
    step_to(n + 3);
    cif.cfg_valid = 1'b0;

    // 5: ch2 BLINK period 0 accepted on a tick edge; then out-of-range channel
    te = next_tick(cyc + 1);
    step_to(te - 1);
    expect_at(te - 1, K_TICK, 3'b001, 3'b001, "tick_at_cfg");
    cfg(2, M_BLINK, 0, 0, e);
    n_tests++;
    if (e != te) begin
      n_fail++;
      $display("FAIL accept_on_tick: got edge %0d expected edge %0d", e, te);
    end
    expect_at(te + 1, K_LED, 3'b100, 3'b100, "p0_on");
    expect_at(te + 10, K_LED, 3'b100, 3'b100, "p0_hold");
    expect_at(te + 11, K_LED, 3'b100, 3'b000, "p0_off");
    expect_at(te + 20, K_LED, 3'b100, 3'b000, "p0_off_hold");
    expect_at(te + 21, K_LED, 3'b100, 3'b100, "p0_on2");
    cfg(3, M_ON, 0, 0, f);
    expect_at(f, K_RDY, 3'b001, 3'b000, "bad_ch_rdy_lo");
    expect_at(f + 1, K_RDY, 3'b001, 3'b001, "bad_ch_rdy_hi");
    for (int m = f + 1; m <= f + 5; m++)
      expect_at(m, K_LED, 3'b001, 3'b000, "bad_ch_led0");

    // 6: ch0 ON, then reset mid-blink
    step_to(a + 101);
    cfg(0, M_ON, 0, 0, g);
    expect_at(g + 1, K_LED, 3'b001, 3'b001, "ch0_on");
    expect_at(g + 2, K_LED, 3'b001, 3'b001, "ch0_on2");
    step_to(g + 3);
    reset = 1'b0;
    expect_at(g + 4, K_LED, 3'b111, 3'b000, "mid_rst_led");
    expect_at(g + 4, K_RDY, 3'b001, 3'b000, "mid_rst_rdy");
    expect_at(g + 4, K_TICK, 3'b001, 3'b000, "mid_rst_tick");
    step_to(g + 5);
    reset = 1'b1;
    expect_at(g + 6, K_RDY, 3'b001, 3'b001, "rerel_rdy");
    expect_at(g + 13, K_TICK, 3'b001, 3'b000, "rerel_tick_pre");
    expect_at(g + 14, K_TICK, 3'b001, 3'b001, "rerel_tick");
    for (int m = g + 6; m <= g + 40; m++)
      expect_at(m, K_LED, 3'b111, 3'b000, "all_off");

    step_to(g + 42);
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got unchecked expected checked at cyc %0d", sb[i].name, sb[i].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
